pn_wave_shaper: RTL and testbench

- Downstream of the PN sequence generator in the AWG pseudo-random (noise/PRBS) output path.
- Consumes the serial PN bit stream plus a one-cycle bit strobe. Maps each bit to a programmable high/low DAC level.
- Applies a programmable slew-rate-limited edge between levels and produces one signed DAC sample per clock, with a bit-boundary marker and a transition counter for the sync output and status.

---
 rtl/pn_pkg.sv | 24 ++
 rtl/pn_slew_limiter.sv | 36 +++
 rtl/pn_wave_shaper.sv | 133 +++++++++++++
 tb/tb_pn_wave_shaper.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared types and constants for the AWG PN wave shaper.
// Imported by the shaper top and its slew limiter.
package pn_pkg;

  localparam int PN_DATA_W = 14;
  localparam int PN_CNT_W  = 16;

  // A PN bit equal to this value selects level_hi.
  localparam logic PN_HI_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SLEW = 2'd2
  } pn_state_e;

  function automatic logic pn_eff_bit(
    input logic bit_in,
    input logic inv
  );
    return bit_in ^ inv;
  endfunction

endpackage

// File: rtl/pn_slew_limiter.sv
// Combinational slew clamp: moves cur toward target by at most step.
// A zero step means jump straight to target.
module pn_slew_limiter
  import pn_pkg::*;
#(
  parameter int DATA_W = PN_DATA_W
) (
  input  logic signed [DATA_W-1:0] target,
  input  logic signed [DATA_W-1:0] cur,
  input  logic        [DATA_W-1:0] step,
  output logic signed [DATA_W-1:0] next
);

  logic signed [DATA_W:0] tgt_x;
  logic signed [DATA_W:0] cur_x;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] stp_x;
  logic signed [DATA_W:0] moved;
  logic        [DATA_W:0] mag;
  logic                   neg;
  logic                   snap;

  always_comb begin
    tgt_x = {target[DATA_W-1], target};
    cur_x = {cur[DATA_W-1], cur};
    stp_x = {1'b0, step};
    // One extra bit keeps the full hi-to-lo span representable.
    diff  = tgt_x - cur_x;
    neg   = diff[DATA_W];
    mag   = neg ? $unsigned(-diff) : $unsigned(diff);
    snap  = (step == '0) || (mag <= {1'b0, step});
    moved = neg ? (cur_x - stp_x) : (cur_x + stp_x);
    next  = snap ? target : moved[DATA_W-1:0];
  end

endmodule

// File: rtl/pn_wave_shaper.sv
// Maps a strobed PN bit stream to slew-limited signed DAC samples,
// with a bit-boundary pulse and a level transition counter.
module pn_wave_shaper
  import pn_pkg::*;
#(
  parameter int DATA_W = PN_DATA_W,
  parameter int CNT_W  = PN_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     pn_bit,
  input  logic                     bit_strobe,
  input  logic                     invert,
  input  logic signed [DATA_W-1:0] level_hi,
  input  logic signed [DATA_W-1:0] level_lo,
  input  logic        [DATA_W-1:0] slew_step,
  output logic signed [DATA_W-1:0] dac_out,
  output logic                     sample_valid,
  output logic                     bit_sync,
  output logic                     slewing,
  output logic        [CNT_W-1:0]  edge_count
);

  pn_state_e state_q, state_d;

  logic signed [DATA_W-1:0] dac_q, dac_d;
  logic signed [DATA_W-1:0] target_q, target_d;
  logic        [DATA_W-1:0] step_q, step_d;
  logic        [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic                     cur_bit_q, cur_bit_d;
  logic                     first_q, first_d;
  logic                     sync_pend_q, sync_pend_d;
  logic                     inc_pend_q, inc_pend_d;
  logic                     bit_sync_q, bit_sync_d;

  logic signed [DATA_W-1:0] lim_next;
  logic signed [DATA_W-1:0] new_lvl;
  logic                     eff;

  pn_slew_limiter #(
    .DATA_W (DATA_W)
  ) u_lim (
    .target (target_q),
    .cur    (dac_q),
    .step   (step_q),
    .next   (lim_next)
  );

  always_comb begin
    eff     = pn_eff_bit(pn_bit, invert);
    new_lvl = (eff == PN_HI_BIT) ? level_hi : level_lo;
  end

  always_comb begin
    state_d     = state_q;
    dac_d       = dac_q;
    target_d    = target_q;
    step_d      = step_q;
    cur_bit_d   = cur_bit_q;
    first_d     = first_q;
    sync_pend_d = 1'b0;
    inc_pend_d  = 1'b0;
    bit_sync_d  = sync_pend_q;
    edge_cnt_d  = edge_cnt_q + CNT_W'(inc_pend_q);

    unique case (1'b1)
      !enable: begin
        state_d    = ST_IDLE;
        dac_d      = '0;
        target_d   = '0;
        step_d     = '0;
        cur_bit_d  = 1'b0;
        first_d    = 1'b1;
        bit_sync_d = 1'b0;
        edge_cnt_d = '0;
      end
      enable: begin
        // Output moves toward the target latched at an earlier edge.
        dac_d = lim_next;
        if (bit_strobe) begin
          target_d    = new_lvl;
          step_d      = slew_step;
          sync_pend_d = 1'b1;
          inc_pend_d  = !first_q && (eff != cur_bit_q);
          cur_bit_d   = eff;
          first_d     = 1'b0;
        end
        if ((dac_d != target_d) && (step_d != '0)) begin
          state_d = ST_SLEW;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dac_q       <= '0;
      target_q    <= '0;
      step_q      <= '0;
      cur_bit_q   <= 1'b0;
      first_q     <= 1'b1;
      sync_pend_q <= 1'b0;
      inc_pend_q  <= 1'b0;
      bit_sync_q  <= 1'b0;
      edge_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dac_q       <= dac_d;
      target_q    <= target_d;
      step_q      <= step_d;
      cur_bit_q   <= cur_bit_d;
      first_q     <= first_d;
      sync_pend_q <= sync_pend_d;
      inc_pend_q  <= inc_pend_d;
      bit_sync_q  <= bit_sync_d;
      edge_cnt_q  <= edge_cnt_d;
    end
  end

  assign dac_out      = dac_q;
  assign sample_valid = (state_q != ST_IDLE);
  assign slewing      = (state_q == ST_SLEW);
  assign bit_sync     = bit_sync_q;
  assign edge_count   = edge_cnt_q;

endmodule

// File: tb/tb_pn_wave_shaper.sv
// Directed bench for pn_wave_shaper.
// Inputs change 1ns after posedge; outputs are read at that point.
module tb_pn_wave_shaper;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               pn_bit;
  logic               bit_strobe;
  logic               invert;
  logic signed [13:0] level_hi;
  logic signed [13:0] level_lo;
  logic        [13:0] slew_step;
  logic signed [13:0] dac_out;
  logic               sample_valid;
  logic               bit_sync;
  logic               slewing;
  logic        [15:0] edge_count;

  int checks;
  int failures;

  pn_wave_shaper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pn_bit       (pn_bit),
    .bit_strobe   (bit_strobe),
    .invert       (invert),
    .level_hi     (level_hi),
    .level_lo     (level_lo),
    .slew_step    (slew_step),
    .dac_out      (dac_out),
    .sample_valid (sample_valid),
    .bit_sync     (bit_sync),
    .slewing      (slewing),
    .edge_count   (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    pn_bit     = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
  endtask

  task automatic fresh();
    enable     = 1'b0;
    bit_strobe = 1'b0;
    invert     = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    pn_bit     = 1'b0;
    bit_strobe = 1'b0;
    invert     = 1'b0;
    level_hi   = 14'sd0;
    level_lo   = 14'sd0;
    slew_step  = 14'd0;
    #12;
    checks++;
    if ({dac_out, sample_valid, bit_sync, slewing, edge_count} !== '0) begin
      failures++;
      $display("FAIL reset_vals dac=%0d sv=%b bs=%b sl=%b ec=%0d need all 0",
               dac_out, sample_valid, bit_sync, slewing, edge_count);
    end
    rst_n = 1'b1;
    bit_strobe = 1'b1;
    tick();
    tick();
    bit_strobe = 1'b0;
    checks++;
    if ({dac_out, sample_valid, bit_sync, edge_count} !== '0) begin
      failures++;
      $display("FAIL idle_hold dac=%0d sv=%b bs=%b ec=%0d need all 0",
               dac_out, sample_valid, bit_sync, edge_count);
    end
  endtask

  task automatic test_step0();
    logic b [3];
    int   e [3];
    int   syncs;
    b = '{1'b1, 1'b0, 1'b1};
    e = '{4000, -4000, 4000};
    syncs = 0;
    level_hi  = 14'sd4000;
    level_lo  = -14'sd4000;
    slew_step = 14'd0;
    fresh();
    checks++;
    if (sample_valid !== 1'b1 || dac_out !== 14'sd0) begin
      failures++;
      $display("FAIL hold_entry sv=%b dac=%0d need sv=1 dac=0",
               sample_valid, dac_out);
    end
    for (int i = 0; i < 3; i++) begin
      strobe(b[i]);
      if (bit_sync) syncs++;
      checks++;
      if (slewing !== 1'b0) begin
        failures++;
        $display("FAIL step0_slewing[%0d] got=%b need=0", i, slewing);
      end
      tick();
      if (bit_sync) syncs++;
      checks++;
      if (dac_out !== 14'(e[i]) || bit_sync !== 1'b1) begin
        failures++;
        $display("FAIL step0_jump[%0d] dac=%0d bs=%b need dac=%0d bs=1",
                 i, dac_out, bit_sync, e[i]);
      end
      tick();
      if (bit_sync) syncs++;
    end
    checks++;
    if (edge_count !== 16'd2) begin
      failures++;
      $display("FAIL step0_edges got=%0d need=2", edge_count);
    end
    checks++;
    if (syncs != 3) begin
      failures++;
      $display("FAIL step0_syncs got=%0d need=3", syncs);
    end
  endtask

  task automatic test_slew();
    int e [6];
    int sl_cnt;
    e = '{1000, 2000, 3000, 3500, 3500, 3500};
    level_hi  = 14'sd3500;
    level_lo  = 14'sd0;
    slew_step = 14'd1000;
    fresh();
    strobe(1'b1);
    sl_cnt = slewing ? 1 : 0;
    checks++;
    if (slewing !== 1'b1 || dac_out !== 14'sd0) begin
      failures++;
      $display("FAIL slew_start sl=%b dac=%0d need sl=1 dac=0",
               slewing, dac_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (slewing) sl_cnt++;
      checks++;
      if (dac_out !== 14'(e[i])) begin
        failures++;
        $display("FAIL slew_ramp[%0d] got=%0d need=%0d",
                 i, dac_out, e[i]);
      end
    end
    checks++;
    if (sl_cnt != 4) begin
      failures++;
      $display("FAIL slew_cycles got=%0d need=4", sl_cnt);
    end
    checks++;
    if (edge_count !== 16'd0) begin
      failures++;
      $display("FAIL slew_first_edge got=%0d need=0", edge_count);
    end
  endtask

  task automatic test_retarget();
    int e [6];
    e = '{1000, 500, 0, -500, -1000, -1000};
    level_hi  = 14'sd3000;
    level_lo  = -14'sd1000;
    slew_step = 14'd500;
    fresh();
    strobe(1'b1);
    tick();
    tick();
    strobe(1'b0);
    checks++;
    if (dac_out !== 14'sd1500) begin
      failures++;
      $display("FAIL retarget_at got=%0d need=1500", dac_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dac_out !== 14'(e[i])) begin
        failures++;
        $display("FAIL retarget_ramp[%0d] got=%0d need=%0d",
                 i, dac_out, e[i]);
      end
    end
    checks++;
    if (edge_count !== 16'd1 || slewing !== 1'b0) begin
      failures++;
      $display("FAIL retarget_end ec=%0d sl=%b need ec=1 sl=0",
               edge_count, slewing);
    end
  endtask

  task automatic test_extremes();
    int e [4][3];
    logic b [4];
    logic inv [4];
    e   = '{'{8191, 8191, 8191},
            '{0, -8191, -8192},
            '{-1, 8190, 8191},
            '{0, -8191, -8192}};
    b   = '{1'b1, 1'b0, 1'b1, 1'b1};
    inv = '{1'b0, 1'b0, 1'b0, 1'b1};
    level_hi  = 14'sd8191;
    level_lo  = -14'sd8192;
    slew_step = 14'd8191;
    fresh();
    for (int i = 0; i < 4; i++) begin
      invert = inv[i];
      strobe(b[i]);
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++;
        if (dac_out !== 14'(e[i][j])) begin
          failures++;
          $display("FAIL extreme[%0d][%0d] got=%0d need=%0d",
                   i, j, dac_out, e[i][j]);
        end
      end
    end
    checks++;
    if (edge_count !== 16'd3) begin
      failures++;
      $display("FAIL extreme_edges got=%0d need=3", edge_count);
    end
    invert = 1'b0;
  endtask

  task automatic test_same_bit();
    level_hi  = 14'sd2000;
    level_lo  = 14'sd0;
    slew_step = 14'd0;
    fresh();
    strobe(1'b1);
    tick();
    level_hi = 14'sd2500;
    tick();
    tick();
    checks++;
    if (dac_out !== 14'sd2000) begin
      failures++;
      $display("FAIL same_between got=%0d need=2000", dac_out);
    end
    strobe(1'b1);
    tick();
    checks++;
    if (dac_out !== 14'sd2500 || bit_sync !== 1'b1) begin
      failures++;
      $display("FAIL same_refresh dac=%0d bs=%b need dac=2500 bs=1",
               dac_out, bit_sync);
    end
    tick();
    checks++;
    if (edge_count !== 16'd0) begin
      failures++;
      $display("FAIL same_edges got=%0d need=0", edge_count);
    end
  endtask

  task automatic test_enable_drop();
    level_hi  = 14'sd3500;
    level_lo  = 14'sd0;
    slew_step = 14'd1000;
    fresh();
    strobe(1'b1);
    tick();
    strobe(1'b0);
    tick();
    checks++;
    if (dac_out !== 14'sd1000 || edge_count !== 16'd1) begin
      failures++;
      $display("FAIL drop_pre dac=%0d ec=%0d need dac=1000 ec=1",
               dac_out, edge_count);
    end
    enable     = 1'b0;
    pn_bit     = 1'b1;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    checks++;
    if ({dac_out, sample_valid, bit_sync, slewing, edge_count} !== '0) begin
      failures++;
      $display("FAIL drop_idle dac=%0d sv=%b bs=%b sl=%b ec=%0d need all 0",
               dac_out, sample_valid, bit_sync, slewing, edge_count);
    end
  endtask

  task automatic test_reset_mid();
    level_hi  = 14'sd3500;
    level_lo  = 14'sd0;
    slew_step = 14'd1000;
    fresh();
    strobe(1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dac_out, sample_valid, bit_sync, slewing, edge_count} !== '0) begin
      failures++;
      $display("FAIL async_rst dac=%0d sv=%b sl=%b ec=%0d need all 0",
               dac_out, sample_valid, slewing, edge_count);
    end
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (dac_out !== 14'sd0 || sample_valid !== 1'b1 || slewing !== 1'b0) begin
      failures++;
      $display("FAIL post_rst dac=%0d sv=%b sl=%b need dac=0 sv=1 sl=0",
               dac_out, sample_valid, slewing);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_step0();
    test_slew();
    test_retarget();
    test_extremes();
    test_same_bit();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
